// File: rtl/rf_port_arbiter_if.sv
// rf_port_arbiter_if: requester handshakes plus register-file port bundle
interface rf_port_arbiter_if #(parameter int DW = 32, parameter int AW = 5);
  logic req0, req1, lock0, lock1, we0, we1;
  logic [AW-1:0] ra1_0, ra2_0, ra1_1, ra2_1, wa_0, wa_1;
  logic [DW-1:0] wd_0, wd_1;
  logic gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rd1_0, rd2_0, rd1_1, rd2_1;
  logic [AW-1:0] a1, a2, a3;
  logic we3;
  logic [DW-1:0] wd3, rd1, rd2;
  modport slave (
    input  req0, req1, lock0, lock1, we0, we1, ra1_0, ra2_0, ra1_1, ra2_1, wa_0, wa_1, wd_0, wd_1, rd1, rd2,
    output gnt0, gnt1, rvalid0, rvalid1, rd1_0, rd2_0, rd1_1, rd2_1, a1, a2, a3, we3, wd3
  );
  modport master (
    output req0, req1, lock0, lock1, we0, we1, ra1_0, ra2_0, ra1_1, ra2_1, wa_0, wa_1, wd_0, wd_1, rd1, rd2,
    input  gnt0, gnt1, rvalid0, rvalid1, rd1_0, rd2_0, rd1_1, rd2_1, a1, a2, a3, we3, wd3
  );
endinterface

// File: rtl/rf_port_arbiter.sv
// rf_port_arbiter: round-robin/lockable two-requester sequencer for one register-file port set
module rf_port_arbiter #(parameter int DW = 32, parameter int AW = 5) (
  input logic clk,
  input logic rst,
  rf_port_arbiter_if.slave bus
);
  logic issue_valid, issue_id, last_id, lock_valid, lock_id, c_we, acc;
  logic [AW-1:0] c_ra1, c_ra2, c_wa;
  logic [DW-1:0] c_wd;
  // a held lock blocks the other requester even while the owner is idle
  always_comb begin
    bus.gnt0 = !rst && bus.req0 && (lock_valid ? !lock_id : (!bus.req1 || last_id));
    bus.gnt1 = !rst && bus.req1 && (lock_valid ? lock_id : (!bus.req0 || !last_id));
    acc = bus.gnt0 || bus.gnt1;
  end
  assign bus.a1 = c_ra1;
  assign bus.a2 = c_ra2;
  assign bus.a3 = c_wa;
  assign bus.wd3 = c_wd;
  assign bus.we3 = issue_valid && c_we;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_valid <= 1'b0;
      issue_id <= 1'b0;
      last_id <= 1'b1;
      lock_valid <= 1'b0;
      lock_id <= 1'b0;
      c_we <= 1'b0;
      c_ra1 <= '0;
      c_ra2 <= '0;
      c_wa <= '0;
      c_wd <= '0;
      bus.rvalid0 <= 1'b0;
      bus.rvalid1 <= 1'b0;
      bus.rd1_0 <= '0;
      bus.rd2_0 <= '0;
      bus.rd1_1 <= '0;
      bus.rd2_1 <= '0;
    end else begin
      issue_valid <= acc;
      bus.rvalid0 <= issue_valid && !issue_id;
      bus.rvalid1 <= issue_valid && issue_id;
      if (acc) begin
        issue_id <= bus.gnt1;
        last_id <= bus.gnt1;
        lock_id <= bus.gnt1;
        lock_valid <= bus.gnt1 ? bus.lock1 : bus.lock0;
        c_we <= bus.gnt1 ? bus.we1 : bus.we0;
        c_ra1 <= bus.gnt1 ? bus.ra1_1 : bus.ra1_0;
        c_ra2 <= bus.gnt1 ? bus.ra2_1 : bus.ra2_0;
        c_wa <= bus.gnt1 ? bus.wa_1 : bus.wa_0;
        c_wd <= bus.gnt1 ? bus.wd_1 : bus.wd_0;
      end
      if (issue_valid && !issue_id) begin
        bus.rd1_0 <= bus.rd1;
        bus.rd2_0 <= bus.rd2;
      end
      if (issue_valid && issue_id) begin
        bus.rd1_1 <= bus.rd1;
        bus.rd2_1 <= bus.rd2;
      end
    end
  end
endmodule

// File: tb/tb_rf_port_arbiter.sv
// tb_rf_port_arbiter: directed checks of rf_port_arbiter against a behavioural register file
module tb_rf_port_arbiter;
  logic clk, rst, init;
  int checks = 0;
  int errors = 0;
  logic [31:0] rf [32];
  rf_port_arbiter_if bus ();
  rf_port_arbiter dut (.clk(clk), .rst(rst), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'hA000_0000 + 32'(i);
    end else if (bus.we3) begin
      rf[bus.a3] <= bus.wd3;
    end
  end
  assign bus.rd1 = rf[bus.a1];
  assign bus.rd2 = rf[bus.a2];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0b exp=%0b", tag, obs, exp);
    end
  endtask
  task automatic drive0(input logic r, l, w, input logic [4:0] x1, x2, wa, input logic [31:0] wd);
    bus.req0 = r; bus.lock0 = l; bus.we0 = w; bus.ra1_0 = x1; bus.ra2_0 = x2; bus.wa_0 = wa; bus.wd_0 = wd;
  endtask
  task automatic drive1(input logic r, l, w, input logic [4:0] x1, x2, wa, input logic [31:0] wd);
    bus.req1 = r; bus.lock1 = l; bus.we1 = w; bus.ra1_1 = x1; bus.ra2_1 = x2; bus.wa_1 = wa; bus.wd_1 = wd;
  endtask
  initial begin
    rst = 1'b1;
    init = 1'b1;
    drive0(1, 0, 0, 0, 0, 0, 0);
    drive1(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    init = 1'b0;
    #1;
    chkb("rst_gnt0", bus.gnt0, 0);
    chkb("rst_gnt1", bus.gnt1, 0);
    chkb("rst_we3", bus.we3, 0);
    chk("rst_a1", 32'(bus.a1), 0);
    chk("rst_a3", 32'(bus.a3), 0);
    chk("rst_wd3", bus.wd3, 0);
    chkb("rst_rvalid0", bus.rvalid0, 0);
    chk("rst_rd1_0", bus.rd1_0, 0);
    chk("rst_rd2_1", bus.rd2_1, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chkb("tie_gnt0", bus.gnt0, 1);
    chkb("tie_gnt1", bus.gnt1, 0);
    @(negedge clk);
    drive0(0, 0, 0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0, 0, 0);
    #1;
    chkb("tie_issue_we3", bus.we3, 0);
    @(negedge clk);
    #1;
    chkb("tie_rvalid0", bus.rvalid0, 1);
    chk("tie_rd1_0", bus.rd1_0, 32'hA000_0000);
    @(negedge clk);
    drive0(1, 0, 1, 3, 4, 3, 32'hDEAD_BEEF);
    #1;
    chkb("wr_gnt0", bus.gnt0, 1);
    @(negedge clk);
    drive0(1, 0, 0, 3, 5, 0, 0);
    #1;
    chkb("rd_gnt0", bus.gnt0, 1);
    chkb("wr_we3", bus.we3, 1);
    chk("wr_a3", 32'(bus.a3), 3);
    chk("wr_wd3", bus.wd3, 32'hDEAD_BEEF);
    @(negedge clk);
    drive0(0, 0, 0, 0, 0, 0, 0);
    #1;
    chkb("wr_rvalid0", bus.rvalid0, 1);
    chk("wr_old_rd1_0", bus.rd1_0, 32'hA000_0003);
    chk("wr_rd2_0", bus.rd2_0, 32'hA000_0004);
    chkb("rd_we3", bus.we3, 0);
    chk("rd_a1", 32'(bus.a1), 3);
    @(negedge clk);
    #1;
    chkb("rd_rvalid0", bus.rvalid0, 1);
    chk("rd_new_rd1_0", bus.rd1_0, 32'hDEAD_BEEF);
    chk("rd_rd2_0", bus.rd2_0, 32'hA000_0005);
    @(negedge clk);
    #1;
    chkb("rd_rvalid0_pulse", bus.rvalid0, 0);
    chk("rd_hold_rd1_0", bus.rd1_0, 32'hDEAD_BEEF);
    @(negedge clk);
    drive1(1, 0, 0, 3, 0, 0, 0);
    #1;
    chkb("p_gnt1", bus.gnt1, 1);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      drive0(1, 0, 0, 1, 0, 0, 0);
      drive1(1, 0, 0, 2, 0, 0, 0);
      #1;
      chkb($sformatf("rr_gnt0_%0d", i), bus.gnt0, i % 2 == 0);
      chkb($sformatf("rr_gnt1_%0d", i), bus.gnt1, i % 2 == 1);
      chkb($sformatf("rr_rvalid0_%0d", i), bus.rvalid0, i >= 2 && i % 2 == 0);
      chkb($sformatf("rr_rvalid1_%0d", i), bus.rvalid1, i % 2 == 1);
      if (i == 1) chk("p_rd1_1", bus.rd1_1, 32'hDEAD_BEEF);
      @(negedge clk);
    end
    drive0(0, 0, 0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0, 0, 0);
    #1;
    chkb("rr_tail_rvalid0", bus.rvalid0, 1);
    chk("rr_rd1_0", bus.rd1_0, 32'hA000_0001);
    @(negedge clk);
    #1;
    chkb("rr_tail_rvalid1", bus.rvalid1, 1);
    chkb("rr_tail_excl", bus.rvalid0, 0);
    chk("rr_rd1_1", bus.rd1_1, 32'hA000_0002);
    @(negedge clk);
    drive1(1, 1, 0, 2, 0, 0, 0);
    #1;
    chkb("lk0_gnt1", bus.gnt1, 1);
    @(negedge clk);
    for (int i = 1; i < 3; i++) begin
      drive0(1, 0, 0, 1, 0, 0, 0);
      #1;
      chkb($sformatf("lk%0d_gnt1", i), bus.gnt1, 1);
      chkb($sformatf("lk%0d_gnt0", i), bus.gnt0, 0);
      @(negedge clk);
    end
    drive1(1, 0, 0, 2, 0, 0, 0);
    #1;
    chkb("lk3_gnt1", bus.gnt1, 1);
    chkb("lk3_gnt0", bus.gnt0, 0);
    @(negedge clk);
    drive1(0, 0, 0, 0, 0, 0, 0);
    #1;
    chkb("lk4_gnt0", bus.gnt0, 1);
    chkb("lk4_gnt1", bus.gnt1, 0);
    @(negedge clk);
    drive0(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive1(1, 1, 0, 2, 0, 0, 0);
    #1;
    chkb("idle_lock_gnt1", bus.gnt1, 1);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      drive1(0, 0, 0, 0, 0, 0, 0);
      drive0(1, 0, 0, 1, 0, 0, 0);
      #1;
      chkb($sformatf("idle_wait_gnt0_%0d", i), bus.gnt0, 0);
      @(negedge clk);
    end
    drive1(1, 0, 0, 2, 0, 0, 0);
    #1;
    chkb("idle_unlock_gnt1", bus.gnt1, 1);
    chkb("idle_unlock_gnt0", bus.gnt0, 0);
    @(negedge clk);
    drive1(0, 0, 0, 0, 0, 0, 0);
    #1;
    chkb("idle_after_gnt0", bus.gnt0, 1);
    @(negedge clk);
    drive0(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    drive1(1, 1, 1, 0, 0, 5, 32'h5555_5555);
    #1;
    chkb("mid_gnt1", bus.gnt1, 1);
    @(negedge clk);
    drive1(0, 0, 0, 0, 0, 0, 0);
    #1;
    chkb("mid_we3_pre", bus.we3, 1);
    chk("mid_a3_pre", 32'(bus.a3), 5);
    rst = 1'b1;
    #1;
    chkb("mid_we3_async", bus.we3, 0);
    @(negedge clk);
    rst = 1'b0;
    drive0(1, 0, 0, 5, 0, 0, 0);
    #1;
    chkb("mid_no_rvalid1", bus.rvalid1, 0);
    chkb("mid_lock_cleared_gnt0", bus.gnt0, 1);
    @(negedge clk);
    drive0(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chkb("mid_rvalid0", bus.rvalid0, 1);
    chk("mid_reg5_unchanged", bus.rd1_0, 32'hA000_0005);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_port_arbiter.md
# rf_port_arbiter

Two-requester arbiter and sequencer for the 32x32 register file's single port set (two read addresses, one write port with enable). It accepts at most one register-file operation per cycle from requester 0 or 1, registers it, drives the register-file ports for exactly one issue cycle, and returns the read data to the winning requester one cycle later. Arbitration is round-robin, with an optional lock so one requester can run an uninterrupted multi-operation sequence.

## Interface
- DW, 32, data width; matches WD3/RD1/RD2
- AW, 5, register address width; matches A1/A2/A3
- CLK  in  1  clock; all state updates on posedge
- RESET  in  1  asynchronous, active-high reset
- req0 / req1  in  1  operation request; held with its fields stable until the matching gnt is high
- lock0 / lock1  in  1  with req: keep ownership after this operation
- we0 / we1  in  1  operation writes wd to wa
- ra1_0, ra2_0 / ra1_1, ra2_1  in  AW  read addresses
- wa_0 / wa_1  in  AW  write address
- wd_0 / wd_1  in  DW  write data
- gnt0 / gnt1  out  1  combinational; the operation is accepted at the edge ending this cycle
- rvalid0 / rvalid1  out  1  one-cycle pulse; rd1_k/rd2_k valid
- rd1_0, rd2_0 / rd1_1, rd2_1  out  DW  returned read data; held until the next rvalid_k
- A1, A2, A3  out  AW  register-file read and write addresses
- WE3  out  1  register-file write enable
- WD3  out  DW  register-file write data
- RD1, RD2  in  DW  combinational register-file read data

## Operation
- **State:**
  - issue_valid, issue_id: which requester is being issued
  - captured op: ra1, ra2, wa, wd, we
  - last_id: round-robin pointer
  - lock_valid, lock_id
  - rvalid_k and rd data registers
- **Grant rules, evaluated each cycle; at most one gnt high:**
  - lock_valid=1: only lock_id may be granted, when its req is high. The other requester waits, even if the owner is idle.
  - lock_valid=0, single req: grant it.
  - lock_valid=0, both req: grant the requester != last_id.
  - While RESET=1: gnt0=gnt1=0.
- **On accept (gnt_k at posedge):**
  - Capture k's fields and set issue_valid=1, issue_id=k, last_id=k.
  - lock_valid becomes lock_k with lock_id=k. A granted op with lock_k=0 releases the lock.
- **No accept at posedge:** issue_valid=0.
- **Issue cycle:**
  - A1/A2/A3/WD3 come from the captured regs.
  - WE3 = issue_valid & captured we.
  - When not issuing, A1/A2/A3/WD3 hold their last values and WE3=0.
- **Return:**
  - At the posedge ending an issue cycle, RD1/RD2 are latched into rd1/rd2 of issue_id, and rvalid_{issue_id}=1 for the next cycle only.
  - The other requester's rd registers are unchanged.
- **Read/write ordering:** reads in an issue cycle see register state before that cycle's write, because the write lands at the same edge. The next issued op sees the write.
- **Address handling:** addresses pass through unmodified; no decoding or range checks.
- **Reset values:** all outputs 0; issue_valid=0, lock_valid=0, last_id=1 (requester 0 wins the first tie), captured regs 0.

## Timing
- **Latency:** gnt in cycle N → ports driven in N+1 → register-file write and data capture at the end of N+1 → rvalid in N+2. Read latency is 2 cycles from the grant edge.
- **Throughput:** one op per cycle with back-to-back accepts; alternating grants when both requesters are continuously requesting and unlocked.
- **Lock and requester behaviour:**
  - The lock takes effect for the grant decision in the cycle after the accepting edge.
  - A requester may reassert req in the cycle after its gnt for a new op.
  - A requester must not change its fields while req=1 and gnt=0.
- **Reset mid-operation:** RESET asserted during an issue cycle forces WE3=0 immediately (asynchronous). That write is lost, the pending rvalid is dropped and the lock is cleared.
- **Simultaneous events:**
  - rvalid_k for op i and gnt_k for op i+2 may be high in the same cycle.
  - rvalid0 and rvalid1 are never high together.

## Test plan
- **Reset:** RESET pulse → all outputs 0. First cycle with req0=req1=1 → gnt0=1, gnt1=0.
- **Write then read:** req0 with we0=1, wa_0=3, wd_0=0xDEADBEEF, accepted at cycle N. Then req0 read with ra1_0=3, accepted at N+1. Required: WE3=1, A3=3 in N+1; rvalid0 in N+3 with rd1_0=0xDEADBEEF. The first op's rvalid0 in N+2 shows the old reg3 value.
- **Round-robin:** both reqs held high for 6 cycles → grants 0,1,0,1,0,1. rvalid pulses alternate, two cycles behind the grants.
- **Lock:** req1 with lock1=1 for 3 ops while req0 is held → gnt1 for 3 consecutive cycles, gnt0=0. The 4th op with lock1=0 is granted, and gnt0=1 on the next cycle.
- **Lock with idle owner:** lock held by 1, req1 drops for 2 cycles, req0=1 → gnt0 stays 0 until requester 1 issues an unlocked op.
- **Reset mid-issue:** RESET asserted in the issue cycle of a write to reg 5 → WE3=0, reg5 unchanged, no rvalid, lock_valid=0.
